// File: rtl/regfile_wb_queue.sv
// ============================================================================
// regfile_wb_queue
// ----------------------------------------------------------------------------
// Write-back queue in front of the 64-bit register file's single write port.
// It accepts results from two producers: A (the ALU), which has priority, and
// B (the load/mul unit). Results are queued in acceptance order and drained
// into the regfile at a rate of at most one write per cycle. Writes to X0 are
// handshaken normally and then dropped.
//
// Optional feature:
//   WB_BYPASS_EN - when defined, the two read indices are compared against
//                  every pending entry. The youngest matching data is
//                  returned, so the reader sees values that have not yet
//                  reached the regfile. When undefined, the bypass outputs
//                  are tied to zero and the read indices are ignored.
// ============================================================================
module regfile_wb_queue #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       a_valid,
    output logic                       a_ready,
    input  logic [4:0]                 a_rd,
    input  logic [DATA_W-1:0]          a_data,

    input  logic                       b_valid,
    output logic                       b_ready,
    input  logic [4:0]                 b_rd,
    input  logic [DATA_W-1:0]          b_data,

    input  logic                       wb_hold,

    output logic                       rf_write,
    output logic [4:0]                 rf_writenum,
    output logic [DATA_W-1:0]          rf_write_data,

    output logic [$clog2(DEPTH):0]     q_count,
    output logic                       q_empty,
    output logic                       q_full,

    input  logic [4:0]                 readnum1,
    input  logic [4:0]                 readnum2,
    output logic                       byp_hit1,
    output logic                       byp_hit2,
    output logic [DATA_W-1:0]          byp_data1,
    output logic [DATA_W-1:0]          byp_data2
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Queue storage and bookkeeping
    logic [4:0]        rd_q   [DEPTH];
    logic [4:0]        rd_d   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Handshake / drain control
    logic              drain;
    logic [CNT_W-1:0]  free;
    logic              a_push;
    logic              b_push;
    logic [PTR_W-1:0]  b_slot;

    // Drain decision and ready generation. A slot freed by this cycle's drain
    // counts as free, so a full queue still accepts one result while draining.
    always_comb begin
        drain   = (count_q != '0) && !wb_hold;
        free    = DEPTH_C - count_q + CNT_W'(drain);
        a_ready = (free != '0);
        b_ready = (free >= CNT_W'(2)) || ((free == CNT_W'(1)) && !a_valid);
        // X0 results complete their handshake but never occupy a slot.
        a_push  = a_valid && a_ready && (a_rd != 5'd0);
        b_push  = b_valid && b_ready && (b_rd != 5'd0);
    end

    // Next-state for the storage, pointers and occupancy. A lands ahead of B,
    // so on equal rd the later write (B) is the one that sticks.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        rd_d    = rd_q;
        data_d  = data_q;
        b_slot  = tail_q + PTR_W'(a_push);
        if (a_push) begin
            rd_d[tail_q]   = a_rd;
            data_d[tail_q] = a_data;
        end
        if (b_push) begin
            rd_d[b_slot]   = b_rd;
            data_d[b_slot] = b_data;
        end
        tail_d  = tail_q + PTR_W'(a_push) + PTR_W'(b_push);
        head_d  = head_q + PTR_W'(drain);
        count_d = count_q + CNT_W'(a_push) + CNT_W'(b_push) - CNT_W'(drain);
    end

    // Control state: pointers and occupancy, cleared by reset at any time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload storage.
    // NOTE: payload is not reset; an entry is only observed while count_q covers it, so stale contents are harmless.
    always_ff @(posedge clk) begin
        rd_q   <= rd_d;
        data_q <= data_d;
    end

    // Regfile write port, driven straight from the head entry. The head pops
    // on the same edge that the regfile captures it.
    always_comb begin
        rf_write      = drain;
        rf_writenum   = drain ? rd_q[head_q]   : 5'd0;
        rf_write_data = drain ? data_q[head_q] : '0;
    end

    // Occupancy status
    always_comb begin
        q_count = count_q;
        q_empty = (count_q == '0);
        q_full  = (count_q == DEPTH_C);
    end

`ifdef WB_BYPASS_EN
    logic [PTR_W-1:0] scan_idx;

    // Bypass lookup: scan the queue oldest to youngest so the youngest match
    // wins. The head that is being drained this cycle is still included.
    always_comb begin
        byp_hit1  = 1'b0;
        byp_hit2  = 1'b0;
        byp_data1 = '0;
        byp_data2 = '0;
        scan_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                if ((readnum1 != 5'd0) && (rd_q[scan_idx] == readnum1)) begin
                    byp_hit1  = 1'b1;
                    byp_data1 = data_q[scan_idx];
                end
                if ((readnum2 != 5'd0) && (rd_q[scan_idx] == readnum2)) begin
                    byp_hit2  = 1'b1;
                    byp_data2 = data_q[scan_idx];
                end
            end
        end
    end
`else
    logic unused_readnum;

    // Bypass disabled: the outputs are tied off and the read indices are ignored.
    always_comb begin
        byp_hit1       = 1'b0;
        byp_hit2       = 1'b0;
        byp_data1      = '0;
        byp_data2      = '0;
        unused_readnum = ^{readnum1, readnum2};
    end
`endif

endmodule
